// File: rtl/scan_sequencer_pkg.sv
// ============================================================================
// Module   : scan_sequencer_pkg
// Purpose  : Shared state encoding and channel-count constants for the scan
//            sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package scan_sequencer_pkg;
  localparam int NCH = 4;
  localparam int IW  = $clog2(NCH);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;
endpackage

`default_nettype wire

// File: rtl/scan_sequencer_next_channel.sv
// ============================================================================
// Module   : next_channel
// Purpose  : Combinational search for the next higher set mask bit above the
//            current index, falling back to the lowest set bit with a wrap flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module next_channel
  import scan_sequencer_pkg::*;
(
  input  logic [NCH-1:0] mask_i,
  input  logic [IW-1:0]  cur_i,
  output logic [IW-1:0]  next_o,
  output logic           wrap_o
);

  logic [IW-1:0] w_lowest;
  logic [IW-1:0] w_higher;
  logic          w_found;

  // Descending scans: the last hit kept is the smallest qualifying index.
  always_comb begin
    w_lowest = '0;
    w_higher = '0;
    w_found  = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask_i[i]) begin
        w_lowest = IW'(i);
        if (i > int'(cur_i)) begin
          w_higher = IW'(i);
          w_found  = 1'b1;
        end
      end
    end
  end

  assign next_o = w_found ? w_higher : w_lowest;
  assign wrap_o = ~w_found;

endmodule

`default_nettype wire

// File: rtl/scan_sequencer.sv
// ============================================================================
// Module   : scan_sequencer
// Purpose  : Steps a 2-to-4 decoder through the enabled channels, holding each
//            for DWELL+1 cycles, in single-sweep or continuous mode.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module scan_sequencer
  import scan_sequencer_pkg::*;
#(
  parameter int DW = 4
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          start_i,
  input  logic          stop_i,
  input  logic          mode_i,
  input  logic [NCH-1:0] mask_i,
  input  logic [DW-1:0] dwell_i,
  output logic          a0_o,
  output logic          a1_o,
  output logic          en_o,
  output logic          busy_o,
  output logic          done_o
);

  state_e          state_q;
  logic            mode_q;
  logic [NCH-1:0]  mask_q;
  logic [DW-1:0]   dwell_q;
  logic [DW-1:0]   cnt_q;
  logic [IW-1:0]   idx_q;
  logic            en_q;
  logic            done_q;

  logic [IW-1:0]   w_next_idx;
  logic            w_wrap;
  logic [IW-1:0]   w_first_idx;
  logic            w_first_wrap_unused;
  logic [DW-1:0]   cnt_d;

  next_channel u_next (
    .mask_i (mask_q),
    .cur_i  (idx_q),
    .next_o (w_next_idx),
    .wrap_o (w_wrap)
  );

  // Searching above the top index always wraps, yielding the lowest set bit.
  next_channel u_first (
    .mask_i (mask_i),
    .cur_i  (IW'(NCH - 1)),
    .next_o (w_first_idx),
    .wrap_o (w_first_wrap_unused)
  );

  assign cnt_d = cnt_q - DW'(1);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      mask_q  <= '0;
      dwell_q <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i && !stop_i && (mask_i != '0)) begin
            state_q <= SCAN;
            mode_q  <= mode_i;
            mask_q  <= mask_i;
            dwell_q <= dwell_i;
            cnt_q   <= dwell_i;
            idx_q   <= w_first_idx;
            en_q    <= 1'b1;
          end
        end
        SCAN: begin
          if (stop_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            en_q    <= 1'b0;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_d;
          end else if (!w_wrap || mode_q) begin
            idx_q <= w_next_idx;
            cnt_q <= dwell_q;
          end else begin
            state_q <= IDLE;
            idx_q   <= '0;
            en_q    <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          en_q    <= 1'b0;
        end
      endcase
    end
  end

  assign a0_o   = idx_q[0];
  assign a1_o   = idx_q[1];
  assign en_o   = en_q;
  assign busy_o = (state_q == SCAN);
  assign done_o = done_q;

endmodule

`default_nettype wire

// File: tb/tb_scan_sequencer.sv
// ============================================================================
// Module   : tb_scan_sequencer
// Purpose  : Directed scoreboard bench for scan_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_scan_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic       mode;
  logic [3:0] mask;
  logic [3:0] dwell;
  wire        a0;
  wire        a1;
  wire        en;
  wire        busy;
  wire        done;

  int checks = 0;
  int errors = 0;

  // Expected output vector: {busy, en, a1, a0, done}
  logic [4:0] sb_q[$];

  scan_sequencer #(.DW(4)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .start_i (start),
    .stop_i  (stop),
    .mode_i  (mode),
    .mask_i  (mask),
    .dwell_i (dwell),
    .a0_o    (a0),
    .a1_o    (a1),
    .en_o    (en),
    .busy_o  (busy),
    .done_o  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] act(input int ch);
    return {1'b1, 1'b1, 2'(ch), 1'b0};
  endfunction

  localparam logic [4:0] IDLE_V = 5'b00000;
  localparam logic [4:0] DONE_V = 5'b00001;

  task automatic pop_chk(input string tag);
    logic [4:0] exp_v;
    logic [4:0] obs_v;
    if (sb_q.size() == 0) begin
      errors++;
      checks++;
      $error("FAIL %s: scoreboard empty, observed %b", tag, {busy, en, a1, a0, done});
      return;
    end
    exp_v = sb_q.pop_front();
    obs_v = {busy, en, a1, a0, done};
    checks++;
    assert (obs_v === exp_v) else begin
      errors++;
      $error("FAIL %s: observed {busy,en,a1,a0,done}=%b expected %b", tag, obs_v, exp_v);
    end
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    #1;
    pop_chk(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    mode  = 1'b0;
    mask  = 4'b0000;
    dwell = 4'd0;

    #2;
    sb_q.push_back(IDLE_V);
    pop_chk("reset_state");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    sb_q.push_back(IDLE_V);
    cyc("post_reset_idle");

    // START with an empty mask is ignored
    start = 1'b1; mask = 4'b0000; dwell = 4'd1;
    sb_q.push_back(IDLE_V);
    cyc("start_mask0");
    // START and STOP together stay idle
    mask = 4'b1111; stop = 1'b1;
    sb_q.push_back(IDLE_V);
    cyc("start_stop_idle");
    start = 1'b0; stop = 1'b0;

    // Single sweep, all channels, dwell 1; START re-pulse mid-scan is ignored
    start = 1'b1; mode = 1'b0; mask = 4'b1111; dwell = 4'd1;
    for (int ch = 0; ch < 4; ch++) begin
      sb_q.push_back(act(ch));
      sb_q.push_back(act(ch));
    end
    sb_q.push_back(DONE_V);
    sb_q.push_back(IDLE_V);
    cyc("sweep_c0a");
    start = 1'b0;
    cyc("sweep_c0b");
    start = 1'b1; mask = 4'b0001; dwell = 4'd5; mode = 1'b1;
    cyc("sweep_c1a");
    start = 1'b0;
    for (int k = 0; k < 5; k++) cyc("sweep_rest");
    cyc("sweep_done");
    cyc("sweep_after_done");

    // Masked sweep, channels 1 and 3, dwell 0
    start = 1'b1; mode = 1'b0; mask = 4'b1010; dwell = 4'd0;
    sb_q.push_back(act(1));
    sb_q.push_back(act(3));
    sb_q.push_back(DONE_V);
    sb_q.push_back(IDLE_V);
    cyc("masked_ch1");
    start = 1'b0;
    cyc("masked_ch3");
    cyc("masked_done");
    cyc("masked_idle");

    // Continuous wrap over channels 0 and 3, dwell 2, then STOP
    start = 1'b1; mode = 1'b1; mask = 4'b1001; dwell = 4'd2;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 3; k++) sb_q.push_back(act(0));
      for (int k = 0; k < 3; k++) sb_q.push_back(act(3));
    end
    sb_q.push_back(act(0));
    cyc("cont_first");
    start = 1'b0;
    for (int k = 0; k < 12; k++) cyc("cont_wrap");
    stop = 1'b1;
    sb_q.push_back(IDLE_V);
    cyc("cont_stop");
    stop = 1'b0;
    sb_q.push_back(IDLE_V);
    cyc("cont_stop_after");

    // Single channel continuous hold
    start = 1'b1; mode = 1'b1; mask = 4'b0100; dwell = 4'd0;
    for (int k = 0; k < 4; k++) sb_q.push_back(act(2));
    cyc("hold_first");
    start = 1'b0;
    for (int k = 0; k < 3; k++) cyc("hold_ch2");

    // Asynchronous reset mid-scan, then a fresh START is required
    #2 rst_n = 1'b0;
    #1;
    sb_q.push_back(IDLE_V);
    pop_chk("reset_async");
    sb_q.push_back(IDLE_V);
    sb_q.push_back(IDLE_V);
    cyc("reset_hold1");
    cyc("reset_hold2");
    rst_n = 1'b1;
    sb_q.push_back(IDLE_V);
    sb_q.push_back(IDLE_V);
    cyc("reset_release1");
    cyc("reset_release2");
    start = 1'b1; mode = 1'b0; mask = 4'b1100; dwell = 4'd0;
    sb_q.push_back(act(2));
    sb_q.push_back(act(3));
    sb_q.push_back(DONE_V);
    cyc("restart_ch2");
    start = 1'b0;
    cyc("restart_ch3");
    cyc("restart_done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
